// File: rtl/binary_adder_subtracter_if.sv
// Operand/result bundle for the adder/subtracter.
// The master drives the operands and mode; the slave returns the registered result.
interface binary_adder_subtracter_if #(
  parameter int width = 4
);
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             s;
  logic [width-1:0] sum;
  logic             v;
  logic             cout;

  modport master (
    output a, b, s,
    input  sum, v, cout
  );

  modport slave (
    input  a, b, s,
    output sum, v, cout
  );
endinterface

// File: rtl/binary_adder_subtracter.sv
// Two's-complement ripple-carry adder/subtracter with a registered result.
// s=1 computes a + ~b + 1; v flags signed overflow, cout is the MSB carry.
module binary_adder_subtracter #(
  parameter int width = 4
) (
  input  logic clk,
  input  logic rst,
  binary_adder_subtracter_if.slave bus
);

  logic [width:0]   c;
  logic [width-1:0] sum_d, sum_q;
  logic             v_d, v_q;
  logic             cout_d, cout_q;
  logic             x, y;

  always_comb begin
    c      = '0;
    sum_d  = '0;
    x      = 1'b0;
    y      = 1'b0;
    c[0]   = bus.s;
    for (int i = 0; i < width; i++) begin
      x        = bus.a[i];
      y        = bus.b[i] ^ bus.s;
      sum_d[i] = x ^ y ^ c[i];
      c[i+1]   = (x & y) | (c[i] & (x ^ y));
    end
    // carry into vs out of the sign bit disagree only on signed overflow
    v_d    = c[width] ^ c[width-1];
    cout_d = c[width];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      v_q    <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      v_q    <= v_d;
      cout_q <= cout_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.v    = v_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_binary_adder_subtracter.sv
// Bench for binary_adder_subtracter: directed literal vectors plus an
// exhaustive 4-bit sweep checked every negedge against an arithmetic model.
module tb_binary_adder_subtracter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  binary_adder_subtracter_if #(.width(4)) bus ();

  binary_adder_subtracter #(.width(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: true signed result, wrapped; carry from unsigned compare.
  function automatic void model(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       s,
    output logic [3:0] rs,
    output logic       rv,
    output logic       rc
  );
    int sa = $signed(a);
    int sb = $signed(b);
    int ua = a;
    int ub = b;
    int t;
    t  = s ? (sa - sb) : (sa + sb);
    rs = t[3:0];
    rv = (t > 7) || (t < -8);
    rc = s ? (ua >= ub) : ((ua + ub) > 15);
  endfunction

  task automatic chk(
    input string      name,
    input logic [3:0] gs,
    input logic       gv,
    input logic       gc,
    input logic [3:0] es,
    input logic       ev,
    input logic       ec
  );
    checks++;
    if (gs !== es || gv !== ev || gc !== ec) begin
      errors++;
      $display("FAIL %s: got sum=%b v=%b cout=%b, expected sum=%b v=%b cout=%b",
               name, gs, gv, gc, es, ev, ec);
    end
  endtask

  logic [3:0] e_sum;
  logic       e_v, e_cout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_sum  <= 4'b0;
      e_v    <= 1'b0;
      e_cout <= 1'b0;
    end else begin
      logic [3:0] ms;
      logic       mv, mc;
      model(bus.a, bus.b, bus.s, ms, mv, mc);
      e_sum  <= ms;
      e_v    <= mv;
      e_cout <= mc;
    end
  end

  always @(negedge clk)
    chk("model", bus.sum, bus.v, bus.cout, e_sum, e_v, e_cout);

  task automatic apply(
    input string      name,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       s,
    input logic [3:0] es,
    input logic       ev,
    input logic       ec
  );
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.s = s;
    @(posedge clk);
    #1;
    chk(name, bus.sum, bus.v, bus.cout, es, ev, ec);
  endtask

  initial begin
    rst   = 1'b1;
    bus.a = 4'b0;
    bus.b = 4'b0;
    bus.s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", bus.sum, bus.v, bus.cout, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    apply("1+3",     4'b0001, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0);
    apply("4-2",     4'b0100, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b1);
    apply("2-4",     4'b0010, 4'b0100, 1'b1, 4'b1110, 1'b0, 1'b0);
    apply("-4+-6",   4'b1100, 4'b1010, 1'b0, 4'b0110, 1'b1, 1'b1);
    apply("7-(-8)",  4'b0111, 4'b1000, 1'b1, 4'b1111, 1'b1, 1'b0);
    apply("-8-1",    4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);
    apply("-1+-1",   4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b0, 1'b1);
    apply("4+6",     4'b0100, 4'b0110, 1'b0, 4'b1010, 1'b1, 1'b0);

    // inputs changing between edges must not reach the outputs
    bus.a = 4'b0001;
    bus.b = 4'b0001;
    bus.s = 1'b1;
    #2;
    chk("hold", bus.sum, bus.v, bus.cout, 4'b1010, 1'b1, 1'b0);

    // async reset between edges clears immediately
    rst = 1'b1;
    #1;
    chk("async_rst", bus.sum, bus.v, bus.cout, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply("post_rst", 4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0);

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          @(negedge clk);
          bus.a = a[3:0];
          bus.b = b[3:0];
          bus.s = s[0];
        end
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_adder_subtracter.md
Name: binary_adder_subtracter

Overview:
Parameterised two's-complement adder/subtracter with a registered result. It adds or subtracts two signed operands, selected by a mode bit, and flags signed overflow. The datapath is an explicit ripple-carry chain of full-adder cells followed by one output register stage. It serves as the arithmetic primitive for the datapath; operands are sampled every clock with no handshake.

Parameters:
width, 4, operand and result width in bits (legal range 2 and up); operands and result are two's-complement signed.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
a  input  width  operand A (signed)
b  input  width  operand B (signed)
s  input  1  mode select: 0 = A + B, 1 = A - B
sum  output  width  registered result, modulo 2^width
v  output  1  registered signed-overflow flag for the same result
cout  output  1  registered carry out of the MSB cell (unsigned carry / no-borrow)

Behaviour:
- Reset:
  - rst high asynchronously forces sum = 0, v = 0, cout = 0, regardless of clk.
  - Outputs hold 0 while rst is high.
  - The first capture happens on the first rising clk edge after rst falls.
- Combinational core:
  - Each bit i feeds b[i] XOR s into a full adder.
  - Carry-in to bit 0 is s, so subtraction is computed as A + ~B + 1.
  - Full-adder equations: sum_i = x XOR y XOR c_i; c_(i+1) = x·y + c_i·(x XOR y).
  - The carry ripples from bit 0 to bit width-1.
- Overflow:
  - v_next = c_width XOR c_(width-1), i.e. carry out of MSB XOR carry into MSB.
  - Equivalently: for addition, both operands share a sign and the result sign differs; for subtraction, the operand signs differ and the result sign differs from A.
- cout_next = c_width.
  - In subtract mode, cout = 1 means A >= B when A and B are treated as unsigned (no borrow).
- Latency:
  - a, b and s are sampled at a rising clk edge.
  - sum, v and cout reflect those inputs after that edge (one-cycle latency) and hold until the next edge.
  - One new operation per cycle; full throughput.
- Wrap-around: sum is always the low width bits of the true result. There is no saturation; overflow is only flagged via v.
- Mode change: a change of s between edges has no effect until the next edge. Each cycle is independent, with no internal state beyond the output register.
- Reset mid-operation: the pending result is discarded and outputs clear immediately. Operation resumes from the next post-reset edge.
- Unknown inputs: X on any input is not required to be handled beyond simulation propagation.

Test Plan:
- width=4, rst pulsed high for 2 cycles, then released -> sum=0000, v=0, cout=0 during reset. First edge with a=0001, b=0011, s=0 -> sum=0100 (4), v=0, cout=0.
- a=0100, b=0010, s=1 (4-2) -> sum=0010, v=0, cout=1. Swap operands: a=0010, b=0100, s=1 (2-4) -> sum=1110 (-2), v=0, cout=0.
- Addition overflow: a=0100, b=0110, s=0 (4+6) -> sum=1010, v=1, cout=0. Then a=1100, b=1010, s=0 ((-4)+(-6)) -> sum=0110, v=1, cout=1.
- Subtraction overflow:
  - a=0111, b=1000, s=1 (7-(-8)) -> sum=1111, v=1, cout=0.
  - a=1000, b=0001, s=1 (-8-1) -> sum=0111, v=1, cout=1.
  - Non-overflow edge: a=1111, b=1111, s=0 -> sum=1110, v=0, cout=1.
- Latency and reset mid-operation:
  - Change inputs mid-cycle -> outputs unchanged until the next rising edge.
  - Assert rst asynchronously between edges while sum=1010 -> sum, v and cout go to 0 immediately, without waiting for a clock edge.
- Exhaustive width=4 sweep of all a, b and s (512 vectors) -> each registered sum, v and cout matches the reference model (a ± b) mod 16 with the signed-overflow and carry rules, one cycle after the inputs are applied.
